// File: rtl/bcd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_scan_driver
//  Brief   : Signed value -> BCD (sequential double-dabble), multiplexed onto
//            one shared 7-segment decoder bus with a sign slot.
//  Rev     : 1.0  initial release
// ============================================================================
module bcd_scan_driver #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 1000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  Value,
   input  logic              Load,
   output logic              Busy,
   output logic              Done,
   output logic              Sign,
   output logic              A,
   output logic              B,
   output logic              C,
   output logic              D,
   output logic [DIGITS:0]   An
);

   localparam int c_bcd_w = 4 * DIGITS;
   localparam int c_cnt_w = $clog2(WIDTH + 1);
   localparam int c_pre_w = $clog2(SCAN_DIV);
   localparam int c_idx_w = $clog2(DIGITS + 1);

   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
   localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SCAN_DIV - 1);
   localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t              r_state;
   logic [c_bcd_w-1:0]  r_bcd;
   logic [c_bcd_w-1:0]  r_disp;
   logic [WIDTH-1:0]    r_mag;
   logic [c_cnt_w-1:0]  r_cnt;
   logic                r_neg;
   logic                r_neg_disp;
   logic                r_busy;
   logic                r_done;
   logic [c_pre_w-1:0]  r_pre;
   logic [c_idx_w-1:0]  r_idx;

   logic [WIDTH-1:0]    w_mag;
   logic [c_bcd_w-1:0]  w_bcd_adj;
   logic [DIGITS-1:0]   w_lz;
   logic [3:0]          w_nibble;

   // Unsigned reinterpretation of the negated value: the most negative input
   // maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
   assign w_mag = Value[WIDTH-1] ? (~Value + WIDTH'(1)) : Value;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                   (r_bcd[4*g +: 4] + 4'd3) : r_bcd[4*g +: 4];
      assign w_lz[g] = (r_disp[c_bcd_w-1 : 4*g] == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_bcd      <= '0;
         r_mag      <= '0;
         r_cnt      <= '0;
         r_neg      <= 1'b0;
         r_disp     <= '0;
         r_neg_disp <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Load) begin
                  r_neg   <= Value[WIDTH-1];
                  r_mag   <= w_mag;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
               r_cnt          <= r_cnt + c_cnt_w'(1);
               if (r_cnt == c_cnt_last)
                  r_state <= S_COMMIT;
            end
            S_COMMIT: begin
               r_disp     <= r_bcd;
               r_neg_disp <= r_neg;
               r_done     <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre <= '0;
         r_idx <= '0;
      end else if (r_pre == c_pre_last) begin
         r_pre <= '0;
         r_idx <= (r_idx == c_idx_last) ? '0 : (r_idx + c_idx_w'(1));
      end else begin
         r_pre <= r_pre + c_pre_w'(1);
      end
   end

   // Slot outputs depend only on registered state, so they switch cleanly
   // once per index change.
   always_comb begin
      Sign     = 1'b0;
      w_nibble = 4'b1111;
      An       = '1;
      An[r_idx] = 1'b0;
      if (r_idx == c_idx_last) begin
         Sign = r_neg_disp;
      end else begin
         for (int i = 0; i < DIGITS; i++) begin
            if (int'(r_idx) == i) begin
               if (BLANK_LZ && (i != 0) && w_lz[i])
                  w_nibble = 4'b1111;
               else
                  w_nibble = r_disp[4*i +: 4];
            end
         end
      end
   end

   assign {A, B, C, D} = w_nibble;
   assign Busy = r_busy;
   assign Done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_driver.sv
`default_nettype none
// Scoreboard bench: each accepted Load pushes the hand-computed slot codes;
// a monitor pops on Done, checks its cycle and then reads back one full scan.
module tb_bcd_scan_driver;

   localparam int WIDTH    = 8;
   localparam int DIGITS   = 3;
   localparam int SCAN_DIV = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] value = '0;
   logic             load = 1'b0;

   logic busy1, done1, sign1, a1, b1, c1, d1;
   logic busy0, done0, sign0, a0, b0, c0, d0;
   logic [DIGITS:0] an1, an0;

   bcd_scan_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut_lz (
      .clk(clk), .rst(rst), .Value(value), .Load(load),
      .Busy(busy1), .Done(done1), .Sign(sign1),
      .A(a1), .B(b1), .C(c1), .D(d1), .An(an1)
   );

   bcd_scan_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_all (
      .clk(clk), .rst(rst), .Value(value), .Load(load),
      .Busy(busy0), .Done(done0), .Sign(sign0),
      .A(a0), .B(b0), .C(c0), .D(d0), .An(an0)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] e1;     // {slot3,slot2,slot1,slot0}, each {Sign,A,B,C,D}
      logic [19:0] e0;
      int          dcyc;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   npush = 0;
   int   ndone = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [WIDTH-1:0] v, input logic [19:0] e1,
                          input logic [19:0] e0, input bit push);
      exp_t it;
      value = v;
      load  = 1'b1;
      if (push) begin
         it.e1   = e1;
         it.e0   = e0;
         it.dcyc = cyc + WIDTH + 2;
         sb.push_back(it);
         npush++;
      end
      @(negedge clk);
      load = 1'b0;
   endtask

   function automatic int slot_of(input logic [DIGITS:0] an);
      int s = 0;
      for (int i = 0; i <= DIGITS; i++)
         if (an[i] == 1'b0) s = i;
      return s;
   endfunction

   // Monitor: consumes one expectation per Done pulse.
   initial begin
      exp_t        it;
      logic [19:0] got1, got0;
      forever begin
         @(negedge clk);
         if (done1 === 1'b1) begin
            ndone++;
            check("done_pair", {31'd0, done0}, 32'd1);
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               it = sb.pop_front();
               check("done_cycle", cyc, it.dcyc);
               got1 = 'x;
               got0 = 'x;
               for (int n = 0; n < 4 * SCAN_DIV; n++) begin
                  got1[5*slot_of(an1) +: 5] = {sign1, a1, b1, c1, d1};
                  got0[5*slot_of(an0) +: 5] = {sign0, a0, b0, c0, d0};
                  if (n != 4 * SCAN_DIV - 1) @(negedge clk);
               end
               check("slots_blank_lz", {12'd0, got1}, {12'd0, it.e1});
               check("slots_show_all", {12'd0, got0}, {12'd0, it.e0});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int          idx;
      logic [3:0]  exp_an;
      logic [3:0]  exp_code;

      // Reset and idle scan
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      check("rst_done", {30'd0, done1, done0}, 32'd0);
      check("rst_busy0", {31'd0, busy0}, 32'd0);
      for (int n = 0; n < 20; n++) begin
         idx      = (n / SCAN_DIV) % (DIGITS + 1);
         exp_an   = ~(4'b0001 << idx);
         exp_code = (idx == 0) ? 4'h0 : 4'hF;
         check("rst_scan", {21'd0, an1, sign1, a1, b1, c1, d1, busy1, 1'b0, an0 == an1},
                           {21'd0, exp_an, 1'b0, exp_code, 1'b0, 1'b0, 1'b1});
         @(negedge clk);
      end

      // 123 with Busy window
      do_load(8'h7B, 20'b01111_00001_00010_00011, 20'b01111_00001_00010_00011, 1);
      for (int j = 1; j <= WIDTH + 2; j++) begin
         check("busy_window", {31'd0, busy1}, (j <= WIDTH + 1) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      tick(30);

      // -128
      do_load(8'h80, 20'b11111_00001_00010_01000, 20'b11111_00001_00010_01000, 1);
      tick(45);

      // -5, leading zeros blanked vs shown
      do_load(8'hFB, 20'b11111_01111_01111_00101, 20'b11111_00000_00000_00101, 1);
      tick(45);

      // Load while busy is dropped
      do_load(8'h7B, 20'b01111_00001_00010_00011, 20'b01111_00001_00010_00011, 1);
      tick(1);
      check("busy_on_second_load", {31'd0, busy1}, 32'd1);
      do_load(8'h05, 20'd0, 20'd0, 0);
      tick(45);

      // Reset mid-conversion
      do_load(8'h63, 20'd0, 20'd0, 0);
      tick(2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_state", {24'd0, busy1, an1, sign1, a1 | b1 | c1 | d1, done1},
                           {24'd0, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0});
      tick(20);
      do_load(8'h63, 20'b01111_01111_01001_01001, 20'b01111_00000_01001_01001, 1);
      tick(45);

      // Inner zeros are never blanked; zero shows a single 0
      do_load(8'h64, 20'b01111_00001_00000_00000, 20'b01111_00001_00000_00000, 1);
      tick(45);
      do_load(8'h00, 20'b01111_01111_01111_00000, 20'b01111_00000_00000_00000, 1);
      tick(45);

      check("queue_empty", sb.size(), 32'd0);
      check("done_count", ndone, npush);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
